// File: rtl/fighter_ctrl.sv
// Per-player fighter controller: key vector to position, facing and animation code, stepped on frame_clk ticks.
// Define FIGHTER_JUMP_EN to enable the jump (AIR) state with gravity; otherwise py stays at GROUND_Y.
module fighter_ctrl #(
    parameter int unsigned X_START      = 320,
    parameter int unsigned GROUND_Y     = 400,
    parameter int unsigned X_MIN        = 1,
    parameter int unsigned X_MAX        = 639,
    parameter int unsigned STEP         = 5,
    parameter int unsigned WIDTH        = 60,
    parameter int unsigned HEIGHT       = 70,
    parameter int unsigned WALK_FRAMES  = 8,
    parameter int unsigned WALK_HOLD    = 3,
    parameter int unsigned PUNCH_BASE   = 11,
    parameter int unsigned PUNCH_FRAMES = 4,
    parameter int unsigned PUNCH_HOLD   = 5,
    parameter int unsigned IDLE_CODE    = 9,
    parameter int unsigned JUMP_CODE    = 15,
    parameter int unsigned JUMP_V       = 12,
    parameter int unsigned GRAVITY      = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [3:0] keypress,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] px,
    output logic [9:0] py,
    output logic [9:0] action,
    output logic       direction,
    output logic       is_player,
    output logic       attacking
);

    localparam int unsigned PW = 10;
    localparam int unsigned XW = 11;
    localparam int unsigned CW = 8;

    localparam logic signed [XW-1:0] STEP_S  = XW'(STEP);
    localparam logic signed [XW-1:0] XMIN_S  = XW'(X_MIN);
    localparam logic signed [XW-1:0] XMAX_S  = XW'(X_MAX);
    localparam logic signed [XW-1:0] WIDTH_S = XW'(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_PUNCH, S_AIR} state_e;

    state_e               state_q, state_d;
    logic [PW-1:0]        px_q, px_d, py_q, py_d, action_q, action_d;
    logic                 dir_q, dir_d, atk_q, atk_d;
    logic [CW-1:0]        hcnt_q, hcnt_d, fidx_q, fidx_d;
    logic                 fc_s_q, fc_dl_q, tick_q;
    logic                 prev_punch_q, prev_punch_d;
    logic                 key_punch, key_right, key_left;
    logic                 punch_edge, move_one;
    logic signed [XW-1:0] x_sum;
    logic [PW-1:0]        x_next;

    assign key_punch  = keypress[0];
    assign key_right  = keypress[1];
    assign key_left   = keypress[2];
    assign move_one   = key_right ^ key_left;
    assign punch_edge = key_punch & ~prev_punch_q;

`ifdef FIGHTER_JUMP_EN
    localparam logic signed [PW-1:0] JUMP_V_S  = PW'(JUMP_V);
    localparam logic signed [PW-1:0] GRAVITY_S = PW'(GRAVITY);
    localparam logic signed [XW-1:0] GROUND_S  = XW'(GROUND_Y);

    logic signed [PW-1:0] vy_q, vy_d, vy_cur;
    logic signed [XW-1:0] y_sum;
    logic                 prev_jump_q, prev_jump_d, jump_edge, air_land, air_step;

    assign jump_edge = keypress[3] & ~prev_jump_q;
    // A fresh jump flies with launch speed; otherwise continue the current flight.
    assign vy_cur    = (state_q == S_AIR) ? vy_q : -JUMP_V_S;
    assign y_sum     = $signed({1'b0, py_q}) + $signed({vy_cur[PW-1], vy_cur});
    assign air_land  = (y_sum >= GROUND_S);
`else
    logic jump_unused;
    assign jump_unused = ^{keypress[3], 1'(JUMP_V), 1'(GRAVITY)};
`endif

    // Candidate X after one step in the held direction, saturated to the screen.
    always_comb begin
        x_sum = $signed({1'b0, px_q});
        if (key_right && !key_left) begin
            x_sum = x_sum + STEP_S;
        end else if (key_left && !key_right) begin
            x_sum = x_sum - STEP_S;
        end
        if (x_sum < XMIN_S) begin
            x_next = PW'(X_MIN);
        end else if (x_sum + WIDTH_S > XMAX_S) begin
            x_next = PW'(X_MAX - WIDTH);
        end else begin
            x_next = x_sum[PW-1:0];
        end
    end

    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        dir_d        = dir_q;
        hcnt_d       = hcnt_q;
        fidx_d       = fidx_q;
        prev_punch_d = prev_punch_q;
`ifdef FIGHTER_JUMP_EN
        vy_d         = vy_q;
        prev_jump_d  = prev_jump_q;
        air_step     = 1'b0;
`endif
        if (tick_q) begin
            prev_punch_d = key_punch;
`ifdef FIGHTER_JUMP_EN
            prev_jump_d  = keypress[3];
`endif
            case (state_q)
                S_IDLE, S_WALK: begin
`ifdef FIGHTER_JUMP_EN
                    if (jump_edge) begin
                        air_step = 1'b1;
                    end else
`endif
                    if (punch_edge) begin
                        state_d = S_PUNCH;
                        hcnt_d  = '0;
                        fidx_d  = '0;
                    end else if (move_one) begin
                        state_d = S_WALK;
                        px_d    = x_next;
                        dir_d   = key_right;
                        if (state_q == S_IDLE) begin
                            hcnt_d = '0;
                            fidx_d = '0;
                        end else if (hcnt_q == CW'(WALK_HOLD - 1)) begin
                            hcnt_d = '0;
                            fidx_d = (fidx_q == CW'(WALK_FRAMES - 1)) ? '0 : fidx_q + CW'(1);
                        end else begin
                            hcnt_d = hcnt_q + CW'(1);
                        end
                    end else begin
                        state_d = S_IDLE;
                        hcnt_d  = '0;
                        fidx_d  = '0;
                    end
                end
                S_PUNCH: begin
                    if (hcnt_q == CW'(PUNCH_HOLD - 1)) begin
                        hcnt_d = '0;
                        if (fidx_q == CW'(PUNCH_FRAMES - 1)) begin
                            state_d = S_IDLE;
                            fidx_d  = '0;
                        end else begin
                            fidx_d = fidx_q + CW'(1);
                        end
                    end else begin
                        hcnt_d = hcnt_q + CW'(1);
                    end
                end
                default: begin
`ifdef FIGHTER_JUMP_EN
                    air_step = 1'b1;
`else
                    state_d = S_IDLE;
`endif
                end
            endcase
        end
`ifdef FIGHTER_JUMP_EN
        // One flight tick: steering, ballistic update, snap to ground on landing.
        if (air_step) begin
            if (move_one) begin
                px_d  = x_next;
                dir_d = key_right;
            end
            if (air_land) begin
                py_d    = PW'(GROUND_Y);
                vy_d    = '0;
                state_d = S_IDLE;
                hcnt_d  = '0;
                fidx_d  = '0;
            end else begin
                py_d    = y_sum[PW-1:0];
                vy_d    = vy_cur + GRAVITY_S;
                state_d = S_AIR;
            end
        end
`endif
        case (state_d)
            S_IDLE:  action_d = PW'(IDLE_CODE);
            S_WALK:  action_d = PW'(fidx_d);
            S_PUNCH: action_d = PW'(PUNCH_BASE) + PW'(fidx_d);
            S_AIR:   action_d = PW'(JUMP_CODE);
        endcase
        atk_d = (state_d == S_PUNCH);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fc_s_q       <= 1'b0;
            fc_dl_q      <= 1'b0;
            tick_q       <= 1'b0;
            state_q      <= S_IDLE;
            px_q         <= PW'(X_START);
            py_q         <= PW'(GROUND_Y);
            action_q     <= PW'(IDLE_CODE);
            dir_q        <= 1'b1;
            atk_q        <= 1'b0;
            hcnt_q       <= '0;
            fidx_q       <= '0;
            prev_punch_q <= 1'b0;
`ifdef FIGHTER_JUMP_EN
            vy_q         <= '0;
            prev_jump_q  <= 1'b0;
`endif
        end else begin
            fc_s_q       <= frame_clk;
            fc_dl_q      <= fc_s_q;
            tick_q       <= fc_s_q & ~fc_dl_q;
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            action_q     <= action_d;
            dir_q        <= dir_d;
            atk_q        <= atk_d;
            hcnt_q       <= hcnt_d;
            fidx_q       <= fidx_d;
            prev_punch_q <= prev_punch_d;
`ifdef FIGHTER_JUMP_EN
            vy_q         <= vy_d;
            prev_jump_q  <= prev_jump_d;
`endif
        end
    end

    assign px        = px_q;
    assign py        = py_q;
    assign action    = action_q;
    assign direction = dir_q;
    assign attacking = atk_q;

    // Pixel hit test widened by one bit so the box edge never wraps.
    assign is_player = ({1'b0, DrawX} >= {1'b0, px_q}) &&
                       ({1'b0, DrawX} <  {1'b0, px_q} + XW'(WIDTH)) &&
                       ({1'b0, DrawY} >= {1'b0, py_q}) &&
                       ({1'b0, DrawY} <  {1'b0, py_q} + XW'(HEIGHT));

endmodule

// File: tb/tb_fighter_ctrl.sv
// Bench for fighter_ctrl: directed steps plus random keys, checked against a tick-level behavioural model.
module tb_fighter_ctrl;

`ifdef FIGHTER_JUMP_EN
    localparam bit JUMP_ON = 1'b1;
`else
    localparam bit JUMP_ON = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_WALK  = 1;
    localparam int M_PUNCH = 2;
    localparam int M_AIR   = 3;

    logic       Clk, Reset, frame_clk;
    logic [3:0] keypress;
    logic [9:0] DrawX, DrawY;
    logic [9:0] px, py, action;
    logic       direction, is_player, attacking;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int m_mode, m_px, m_py, m_vy, m_dir, m_wt, m_pt, m_prev_p, m_prev_j;
    int walk_seq[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    int jump_py[3]   = '{388, 377, 367};

    fighter_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_clk (frame_clk),
        .keypress  (keypress),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .px        (px),
        .py        (py),
        .action    (action),
        .direction (direction),
        .is_player (is_player),
        .attacking (attacking)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_px = 320; m_py = 400; m_vy = 0; m_dir = 1;
        m_wt = 0; m_pt = 0; m_prev_p = 0; m_prev_j = 0;
    endtask

    function automatic int stepped_x(input logic [3:0] k);
        int nx;
        nx = m_px;
        if (k[1] && !k[2]) nx = m_px + 5;
        else if (k[2] && !k[1]) nx = m_px - 5;
        if (nx < 1) nx = 1;
        else if (nx + 60 > 639) nx = 639 - 60;
        return nx;
    endfunction

    task automatic fly(input logic [3:0] k);
        if (k[1] != k[2]) begin
            m_px  = stepped_x(k);
            m_dir = int'(k[1]);
        end
        m_py = m_py + m_vy;
        m_vy = m_vy + 1;
        if (m_py >= 400) begin
            m_py = 400; m_vy = 0; m_mode = M_IDLE;
        end
    endtask

    task automatic model_tick(input logic [3:0] k);
        bit pe, je, one;
        pe = k[0] && (m_prev_p == 0);
        je = JUMP_ON && k[3] && (m_prev_j == 0);
        one = (k[1] != k[2]);
        m_prev_p = int'(k[0]);
        m_prev_j = int'(k[3]);
        if (m_mode == M_PUNCH) begin
            m_pt++;
            if (m_pt == 20) m_mode = M_IDLE;
        end else if (m_mode == M_AIR) begin
            fly(k);
        end else if (je) begin
            m_mode = M_AIR;
            m_vy = -12;
            fly(k);
        end else if (pe) begin
            m_mode = M_PUNCH;
            m_pt = 0;
        end else if (one) begin
            m_wt   = (m_mode == M_WALK) ? m_wt + 1 : 0;
            m_mode = M_WALK;
            m_px   = stepped_x(k);
            m_dir  = int'(k[1]);
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    function automatic int exp_action();
        case (m_mode)
            M_WALK:  return (m_wt / 3) % 8;
            M_PUNCH: return 11 + m_pt / 5;
            M_AIR:   return 15;
            default: return 9;
        endcase
    endfunction

    task automatic check_all(input string tag);
        int dx, dy;
        dx = m_px - 10 + int'($urandom_range(0, 80));
        dy = m_py - 10 + int'($urandom_range(0, 90));
        if (dx < 0) dx = 0;
        if (dy < 0) dy = 0;
        DrawX = 10'(dx);
        DrawY = 10'(dy);
        #1;
        check({tag, ".px"}, px, m_px);
        check({tag, ".py"}, py, m_py);
        check({tag, ".action"}, action, exp_action());
        check({tag, ".direction"}, direction, m_dir);
        check({tag, ".attacking"}, attacking, m_mode == M_PUNCH);
        check({tag, ".is_player"}, is_player,
              dx >= m_px && dx < m_px + 60 && dy >= m_py && dy < m_py + 70);
    endtask

    task automatic do_tick(input logic [3:0] k, input string tag);
        keypress  = k;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        check({tag, ".latency"}, action, exp_action());
        repeat (2) @(negedge Clk);
        model_tick(k);
        check_all(tag);
        frame_clk = 1'b0;
        repeat (2) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; keypress = '0; DrawX = '0; DrawY = '0;
        model_reset();
        repeat (3) @(negedge Clk);
        check_all("reset");
        check("reset.px_const", px, 320);
        check("reset.py_const", py, 400);
        check("reset.action_const", action, 9);
        check("reset.dir_const", direction, 1);
        check("reset.atk_const", attacking, 0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 10; i++) begin
            do_tick(4'b0010, "walk_right");
            check("walk_right.seq", action, walk_seq[i]);
        end
        check("walk_right.px_const", px, 370);
        check("walk_right.dir_const", direction, 1);
        do_tick(4'b0000, "stop");
        check("stop.action_const", action, 9);

        for (int i = 0; i < 80; i++) do_tick(4'b0100, "walk_left");
        check("clamp_left.px_const", px, 1);
        check("clamp_left.dir_const", direction, 0);
        for (int i = 0; i < 130; i++) do_tick(4'b0010, "walk_right_edge");
        check("clamp_right.px_const", px, 579);
        do_tick(4'b0110, "both_keys");
        check("both_keys.action_const", action, 9);

        for (int i = 0; i < 30; i++) begin
            do_tick(4'b0001, "punch_hold");
            check("punch_hold.code", action, (i < 20) ? 11 + i / 5 : 9);
        end
        do_tick(4'b0000, "punch_release");
        for (int i = 0; i < 22; i++) begin
            do_tick((i < 2) ? 4'b0001 : 4'b0000, "punch_tap");
            check("punch_tap.code", action, (i < 20) ? 11 + i / 5 : 9);
            check("punch_tap.attacking", attacking, i < 20);
        end
        do_tick(4'b0101, "punch_from_walk");
        check("punch_from_walk.px_frozen", px, 579);
        for (int i = 0; i < 20; i++) do_tick(4'b0000, "punch_drain");

        do_tick(4'b0000, "pre_jump");
`ifdef FIGHTER_JUMP_EN
        for (int i = 0; i < 30; i++) begin
            do_tick(4'b1000, "jump");
            if (i < 3) check("jump.py_const", py, jump_py[i]);
            if (i < 24) check("jump.air_code", action, 15);
            if (i == 24) begin
                check("jump.land_py", py, 400);
                check("jump.land_code", action, 9);
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            do_tick(4'b1000, "jump_off");
            check("jump_off.py_const", py, 400);
            check("jump_off.action_const", action, 9);
        end
`endif

        DrawX = 10'(m_px + 59); DrawY = 10'(m_py);
        #1 check("hit.right_edge_in", is_player, 1);
        DrawX = 10'(m_px + 60);
        #1 check("hit.right_edge_out", is_player, 0);
        DrawX = 10'(m_px); DrawY = 10'(m_py + 69);
        #1 check("hit.bottom_in", is_player, 1);
        DrawY = 10'(m_py + 70);
        #1 check("hit.bottom_out", is_player, 0);
        @(negedge Clk);

        for (int i = 0; i < 200; i++) do_tick(4'($urandom), "random");

        for (int i = 0; i < 45; i++) do_tick(4'b0000, "settle");
        do_tick(4'b0001, "rst_punch");
        do_tick(4'b0001, "rst_punch");
        check("rst_punch.attacking_const", attacking, 1);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check("rst_mid.px", px, 320);
        check("rst_mid.py", py, 400);
        check("rst_mid.action", action, 9);
        check("rst_mid.direction", direction, 1);
        check("rst_mid.attacking", attacking, 0);
        keypress = '0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        do_tick(4'b0001, "post_rst_punch");
        do_tick(4'b0100, "post_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fighter_ctrl.md
# fighter_ctrl

Parametrised per-player fighter controller: converts a 4-bit key vector into position, facing and animation-frame code for one on-screen fighter, updated once per `frame_clk` rising edge. It sits between the keyboard decode and the sprite/colour mapper, with one instance per player. Relative to the fixed single-player block, it adds:
- configurable geometry, step and animation lengths;
- non-interruptible, edge-triggered punches;
- screen clamping;
- optional jump with gravity.

## Interface
Parameters:
- X_START, 320: reset X position.
- GROUND_Y, 400: reset/landing Y position (top edge of sprite).
- X_MIN, 1: leftmost allowed X.
- X_MAX, 639: rightmost allowed X of sprite right edge.
- STEP, 5: horizontal pixels per tick while walking.
- WIDTH, 60: sprite width.
- HEIGHT, 70: sprite height.
- WALK_FRAMES, 8: walk frame codes 0..WALK_FRAMES-1.
- WALK_HOLD, 3: ticks per walk frame.
- PUNCH_BASE, 11: first punch code.
- PUNCH_FRAMES, 4: punch codes PUNCH_BASE..PUNCH_BASE+PUNCH_FRAMES-1.
- PUNCH_HOLD, 5: ticks per punch frame.
- IDLE_CODE, 9: idle frame code.
- JUMP_CODE, 15: airborne frame code.
- JUMP_V, 12: initial upward speed.
- GRAVITY, 1: speed change per tick.

Ports:
- Clk, in, 1: system clock.
- Reset, in, 1: asynchronous, active-low reset.
- frame_clk, in, 1: vertical-sync tick source; asynchronous to the logic and sampled on Clk.
- keypress, in, 4: [0] punch, [1] right, [2] left, [3] jump.
- DrawX, in, 10: current pixel X.
- DrawY, in, 10: current pixel Y.
- px, out, 10: sprite left X.
- py, out, 10: sprite top Y.
- action, out, 10: animation frame code.
- direction, out, 1: facing; 1 = right, 0 = left.
- is_player, out, 1: DrawX/DrawY inside the sprite box.
- attacking, out, 1: high during punch frames.

## Operation
- Tick generation:
  - frame_clk is delayed one Clk.
  - tick is registered as frame_clk & ~delayed.
  - All state below changes only on Clk edges where tick = 1.
- States:
  - IDLE, WALK, PUNCH, AIR.
  - A hold counter `hcnt` and a frame index `fidx` are shared across states.
- IDLE:
  - action = IDLE_CODE.
  - A punch rising edge (punch = 1 with previous-tick punch = 0) enters PUNCH, with fidx = 0 and hcnt = 0.
  - Otherwise, exactly one of left/right held enters WALK with fidx = 0.
  - Punch has priority over walk. Jump has priority over both.
- WALK:
  - X moves by ±STEP.
  - direction = 1 for right, 0 for left.
  - hcnt counts to WALK_HOLD-1, then fidx advances. fidx wraps from WALK_FRAMES-1 to 0.
  - action = fidx.
  - Both left+right held, or neither held, returns to IDLE with hcnt = 0.
  - A punch edge enters PUNCH.
- PUNCH:
  - No X motion.
  - action = PUNCH_BASE + fidx.
  - Each frame is held PUNCH_HOLD ticks.
  - After the last frame, returns to IDLE.
  - Key release does not abort a punch. A held punch key does not retrigger; a new edge is required.
  - direction is frozen.
- AIR (jump):
  - Entered from IDLE/WALK on a jump rising edge while grounded, with vy = -JUMP_V.
  - Each tick: py += vy, then vy += GRAVITY.
  - Left/right still move X and update direction.
  - action = JUMP_CODE. Punch is ignored.
  - Landing: if the next py >= GROUND_Y, then py = GROUND_Y, vy = 0, and the state becomes IDLE.
- X clamp:
  - The new X is computed in 11 bits.
  - Result < X_MIN → X_MIN. Result + WIDTH > X_MAX → X_MAX-WIDTH.
  - No wrap-around is permitted.
- Velocity:
  - vy is 10-bit two's-complement.
  - py update uses sign-extended 11-bit addition.
- is_player:
  - Combinational.
  - High when px <= DrawX < px+WIDTH and py <= DrawY < py+HEIGHT.
- attacking = (state == PUNCH).

## Timing
- Reset (Reset = 0, asynchronous) sets:
  - px = X_START, py = GROUND_Y.
  - action = IDLE_CODE, direction = 1, attacking = 0.
  - state = IDLE, vy = 0, hcnt = fidx = 0.
  - Tick pipeline and previous-key registers cleared.
- Reset release takes effect on the next Clk edge.
- Latency:
  - frame_clk rising edge → tick: 2 Clk.
  - tick → px/py/action/direction updated: 1 Clk.
- Reset asserted mid-punch or mid-air aborts immediately to the reset values.
- Keys are sampled only on tick cycles. Changes between ticks are invisible.
- A frame_clk pulse shorter than one Clk may be missed. Sync pulses are always multi-cycle in this design.

## Configuration
- FIGHTER_JUMP_EN:
  - Defined: AIR state, vy register and keypress[3] are active as above.
  - Undefined: keypress[3] is ignored, AIR is never entered, and py is constant at GROUND_Y. JUMP_V and GRAVITY are unused.

## Test plan
- Reset with defaults → px = 320, py = 400, action = 9, direction = 1, attacking = 0.
- Hold right for 10 ticks → px = 370, direction = 1, action sequence 0,0,0,1,1,1,2,2,2,3.
- Hold left from px = 10 → clamps at px = 1 and never wraps. Hold right near the edge → px saturates at 579.
- Punch held for 30 ticks → codes 11,12,13,14 for 5 ticks each, then 9 held. No retrigger until release and a new press. A release at tick 2 still completes all 20 ticks.
- With FIGHTER_JUMP_EN, jump at py = 400 → py = 388, 377, 367, … peaks and lands exactly at 400, with action = 15 while airborne and then 9. Without the macro, py stays 400.
- DrawX = px+59, DrawY = py → is_player = 1. DrawX = px+60 → 0. Assert reset mid-punch → all outputs return to reset values.
